// File: rtl/sensor_monitor.sv
`default_nettype none
// ============================================================================
// Module   : sensor_monitor
// Purpose  : Sensor error detector. Synchronises the raw sensor lines,
//            classifies each cycle with a critical-mask / count rule,
//            debounces the error condition over DEBOUNCE cycles, then holds
//            a sticky fault until software clears it. Captures a snapshot
//            of the offending pattern and counts fault entries (saturating).
// Ports    : clk        - system clock, rising edge
//            rst        - asynchronous active-high reset
//            sensors    - raw sensor lines, asynchronous to clk
//            clear      - 1-cycle pulse, release a latched fault
//            error      - registered sticky fault flag
//            pending    - registered, error condition seen, debounce running
//            fault_snap - synchronised pattern captured on fault entry
//            fault_cnt  - fault entries since reset, saturating
// Revision : 1.0 - initial release
// ============================================================================
module sensor_monitor #(
    parameter int                     NUM_SENSORS = 4,
    parameter logic [NUM_SENSORS-1:0] CRIT_MASK   = {{(NUM_SENSORS-1){1'b0}}, 1'b1},
    parameter int                     MIN_COUNT   = 2,
    parameter int                     DEBOUNCE    = 3,
    parameter int                     CNT_W       = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_SENSORS-1:0] sensors,
    input  logic                   clear,
    output logic                   error,
    output logic                   pending,
    output logic [NUM_SENSORS-1:0] fault_snap,
    output logic [CNT_W-1:0]       fault_cnt
);

    localparam int PC_W  = $clog2(NUM_SENSORS + 1);
    localparam int DBC_W = $clog2(DEBOUNCE + 1);

    localparam logic [PC_W-1:0]  C_MIN_COUNT = PC_W'(MIN_COUNT);
    localparam logic [DBC_W-1:0] C_DBC_ONE   = DBC_W'(1);
    localparam logic [DBC_W-1:0] C_DBC_LAST  = DBC_W'(DEBOUNCE - 1);
    localparam logic [CNT_W-1:0] C_CNT_ONE   = CNT_W'(1);

    localparam logic [1:0] S_OK    = 2'd0;
    localparam logic [1:0] S_PEND  = 2'd1;
    localparam logic [1:0] S_FAULT = 2'd2;

    logic [NUM_SENSORS-1:0] r_s1;
    logic [NUM_SENSORS-1:0] r_s2;
    logic [1:0]             r_state;
    logic [DBC_W-1:0]       r_dbc;
    logic                   r_error;
    logic                   r_pending;
    logic [NUM_SENSORS-1:0] r_snap;
    logic [CNT_W-1:0]       r_cnt;

    logic [NUM_SENSORS-1:0] w_ncrit;
    logic [PC_W-1:0]        w_ncrit_cnt;
    logic                   w_raw;
    logic [1:0]             w_state_nxt;
    logic [DBC_W-1:0]       w_dbc_nxt;
    logic                   w_enter_fault;
    logic                   w_leave_fault;

    // Two-stage synchroniser; nothing downstream looks at r_s1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= sensors;
            r_s2 <= r_s1;
        end
    end

    // Error classification: any critical sensor, or enough non-critical ones.
    assign w_ncrit = r_s2 & ~CRIT_MASK;

    always_comb begin
        w_ncrit_cnt = '0;
        for (int i = 0; i < NUM_SENSORS; i++) begin
            w_ncrit_cnt = w_ncrit_cnt + {{(PC_W-1){1'b0}}, w_ncrit[i]};
        end
    end

    assign w_raw = (|(r_s2 & CRIT_MASK)) | (w_ncrit_cnt >= C_MIN_COUNT);

    // Next-state logic. The OK state already accounts for the first error
    // cycle, so PEND needs DEBOUNCE-1 more before declaring the fault.
    always_comb begin
        w_state_nxt = r_state;
        w_dbc_nxt   = r_dbc;
        case (r_state)
            S_OK: begin
                if (w_raw) begin
                    if (DEBOUNCE == 1) begin
                        w_state_nxt = S_FAULT;
                        w_dbc_nxt   = '0;
                    end else begin
                        w_state_nxt = S_PEND;
                        w_dbc_nxt   = C_DBC_ONE;
                    end
                end else begin
                    w_dbc_nxt = '0;
                end
            end
            S_PEND: begin
                if (!w_raw) begin
                    w_state_nxt = S_OK;
                    w_dbc_nxt   = '0;
                end else if (r_dbc == C_DBC_LAST) begin
                    w_state_nxt = S_FAULT;
                    w_dbc_nxt   = '0;
                end else begin
                    w_dbc_nxt = r_dbc + C_DBC_ONE;
                end
            end
            S_FAULT: begin
                // Sticky: only a clear while the condition is gone releases it.
                if (clear && !w_raw) begin
                    w_state_nxt = S_OK;
                end
                w_dbc_nxt = '0;
            end
            default: begin
                w_state_nxt = S_OK;
                w_dbc_nxt   = '0;
            end
        endcase
    end

    assign w_enter_fault = (w_state_nxt == S_FAULT) && (r_state != S_FAULT);
    assign w_leave_fault = (r_state == S_FAULT) && (w_state_nxt == S_OK);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_OK;
            r_dbc     <= '0;
            r_error   <= 1'b0;
            r_pending <= 1'b0;
            r_snap    <= '0;
            r_cnt     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_dbc     <= w_dbc_nxt;
            r_error   <= (w_state_nxt == S_FAULT);
            r_pending <= (w_state_nxt == S_PEND);
            if (w_enter_fault) begin
                r_snap <= r_s2;
                if (r_cnt != {CNT_W{1'b1}}) begin
                    r_cnt <= r_cnt + C_CNT_ONE;
                end
            end else if (w_leave_fault) begin
                r_snap <= '0;
            end
        end
    end

    assign error      = r_error;
    assign pending    = r_pending;
    assign fault_snap = r_snap;
    assign fault_cnt  = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_sensor_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_sensor_monitor
// Purpose  : Self-checking bench for sensor_monitor. Table of per-cycle
//            vectors plus hand-written sequences for saturation and
//            asynchronous reset. A second instance uses a 2-bit counter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sensor_monitor;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] sensors;
    logic       clear;
    logic       error,  pending;
    logic [3:0] fault_snap;
    logic [7:0] fault_cnt;
    logic       error2, pending2;
    logic [3:0] fault_snap2;
    logic [1:0] fault_cnt2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sensor_monitor dut (
        .clk        (clk),
        .rst        (rst),
        .sensors    (sensors),
        .clear      (clear),
        .error      (error),
        .pending    (pending),
        .fault_snap (fault_snap),
        .fault_cnt  (fault_cnt)
    );

    sensor_monitor #(.CNT_W(2)) dut2 (
        .clk        (clk),
        .rst        (rst),
        .sensors    (sensors),
        .clear      (clear),
        .error      (error2),
        .pending    (pending2),
        .fault_snap (fault_snap2),
        .fault_cnt  (fault_cnt2)
    );

    typedef struct {
        logic [3:0] s;
        logic       clr;
        logic       err;
        logic       pend;
        logic [3:0] snap;
        logic [7:0] cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [3:0] s, input logic clr, input logic err,
                       input logic pend, input logic [3:0] snap, input logic [7:0] cnt);
        vec_t v;
        v.s = s; v.clr = clr; v.err = err; v.pend = pend; v.snap = snap; v.cnt = cnt;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    int unsigned exp2;

    initial begin
        rst = 1'b1; sensors = 4'b0; clear = 1'b0;
        tick; tick;
        check("reset error",   32'(error),      32'd0);
        check("reset pending", 32'(pending),    32'd0);
        check("reset snap",    32'(fault_snap), 32'd0);
        check("reset cnt",     32'(fault_cnt),  32'd0);
        rst = 1'b0;
        tick; tick;

        // Critical sensor alone: error after 4 edges past first sample.
        add(4'b0001,0, 0,0, 4'b0000,1'b0);
        add(4'b0001,0, 0,0, 4'b0000,0);
        add(4'b0001,0, 0,1, 4'b0000,0);
        add(4'b0001,0, 0,1, 4'b0000,0);
        add(4'b0001,0, 1,0, 4'b0001,1);
        add(4'b0001,0, 1,0, 4'b0001,1);
        // Clear while condition persists is ignored; later clear releases.
        add(4'b0001,1, 1,0, 4'b0001,1);
        add(4'b0000,0, 1,0, 4'b0001,1);
        add(4'b0000,0, 1,0, 4'b0001,1);
        add(4'b0000,0, 1,0, 4'b0001,1);
        add(4'b0000,1, 0,0, 4'b0000,1);
        add(4'b0000,0, 0,0, 4'b0000,1);
        // Count rule: two non-critical sensors.
        add(4'b1100,0, 0,0, 4'b0000,1);
        add(4'b1100,0, 0,0, 4'b0000,1);
        add(4'b1100,0, 0,1, 4'b0000,1);
        add(4'b1100,0, 0,1, 4'b0000,1);
        add(4'b1100,0, 1,0, 4'b1100,2);
        add(4'b0000,0, 1,0, 4'b1100,2);
        add(4'b0000,0, 1,0, 4'b1100,2);
        add(4'b0000,1, 0,0, 4'b0000,2);
        // Two-cycle burst: pending pulses, no fault.
        add(4'b0001,0, 0,0, 4'b0000,2);
        add(4'b0001,0, 0,0, 4'b0000,2);
        add(4'b0000,0, 0,1, 4'b0000,2);
        add(4'b0000,0, 0,1, 4'b0000,2);
        add(4'b0000,0, 0,0, 4'b0000,2);
        add(4'b0000,0, 0,0, 4'b0000,2);
        // Burst with a 1-cycle gap restarts the debounce.
        add(4'b0001,0, 0,0, 4'b0000,2);
        add(4'b0001,0, 0,0, 4'b0000,2);
        add(4'b0000,0, 0,1, 4'b0000,2);
        add(4'b0001,0, 0,1, 4'b0000,2);
        add(4'b0001,0, 0,0, 4'b0000,2);
        add(4'b0000,0, 0,1, 4'b0000,2);
        add(4'b0000,0, 0,1, 4'b0000,2);
        add(4'b0000,0, 0,0, 4'b0000,2);
        add(4'b0000,0, 0,0, 4'b0000,2);

        for (int i = 0; i < vecs.size(); i++) begin
            sensors = vecs[i].s;
            clear   = vecs[i].clr;
            tick;
            check($sformatf("vec%0d error", i),   32'(error),      32'(vecs[i].err));
            check($sformatf("vec%0d pending", i), 32'(pending),    32'(vecs[i].pend));
            check($sformatf("vec%0d snap", i),    32'(fault_snap), 32'(vecs[i].snap));
            check($sformatf("vec%0d cnt", i),     32'(fault_cnt),  32'(vecs[i].cnt));
        end
        clear = 1'b0;

        // Single non-critical sensor never forms an error.
        sensors = 4'b0100;
        for (int i = 0; i < 20; i++) begin
            tick;
            check($sformatf("single nc error c%0d", i),   32'(error),   32'd0);
            check($sformatf("single nc pending c%0d", i), 32'(pending), 32'd0);
        end
        sensors = 4'b0000;
        tick; tick;

        // Five fault/clear rounds: saturation of the 2-bit counter.
        rst = 1'b1; tick; rst = 1'b0;
        exp2 = 0;
        for (int k = 0; k < 5; k++) begin
            sensors = 4'b0001;
            repeat (6) tick;
            exp2 = (exp2 == 3) ? 3 : exp2 + 1;
            check($sformatf("round%0d error", k),  32'(error),      32'd1);
            check($sformatf("round%0d cnt8", k),   32'(fault_cnt),  32'(k + 1));
            check($sformatf("round%0d cnt2", k),   32'(fault_cnt2), 32'(exp2));
            sensors = 4'b0000;
            repeat (3) tick;
            clear = 1'b1; tick; clear = 1'b0;
            check($sformatf("round%0d released", k), 32'(error), 32'd0);
        end

        // Asynchronous reset mid-debounce.
        sensors = 4'b0001;
        repeat (3) tick;
        check("pre-rst pending", 32'(pending), 32'd1);
        #3 rst = 1'b1;
        #1;
        check("async rst pend pending", 32'(pending),   32'd0);
        check("async rst pend cnt",     32'(fault_cnt), 32'd0);
        check("async rst pend error",   32'(error),     32'd0);
        @(negedge clk); rst = 1'b0;
        for (int e = 1; e <= 5; e++) begin
            tick;
            check($sformatf("post-rst edge%0d error", e), 32'(error), (e == 5) ? 32'd1 : 32'd0);
        end
        check("post-rst cnt",  32'(fault_cnt),  32'd1);
        check("post-rst snap", 32'(fault_snap), 32'd1);

        // Asynchronous reset while in FAULT.
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("async rst fault error", 32'(error),      32'd0);
        check("async rst fault snap",  32'(fault_snap), 32'd0);
        check("async rst fault cnt",   32'(fault_cnt),  32'd0);
        check("async rst fault cnt2",  32'(fault_cnt2), 32'd0);
        @(negedge clk); rst = 1'b0; sensors = 4'b0000;
        tick; tick;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
